// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and grant identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of processor fetch/data ports, memory port and status outputs of mem_arbiter.
// slave is the arbiter's view; master is the surrounding processor/memory view.
interface mem_arbiter_if #(
  parameter int MBUS  = 32,
  parameter int CNT_W = 16
);

  logic             if_req;
  logic [MBUS-1:0]  if_addr;
  logic             if_ack;
  logic [MBUS-1:0]  if_rdata;

  logic             d_re;
  logic             d_we;
  logic [MBUS-1:0]  d_addr;
  logic [MBUS-1:0]  d_wdata;
  logic             d_ack;
  logic [MBUS-1:0]  d_rdata;

  logic [MBUS-1:0]  mem_addr;
  logic [MBUS-1:0]  mem_wdata;
  logic             mem_re;
  logic             mem_we;
  logic [MBUS-1:0]  mem_rdata;
  logic             mem_ready;

  logic             stall;
  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we,
           stall, conflict_cnt
  );

  modport master (
    output if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_re, mem_we,
           stall, conflict_cnt
  );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter used to count cycles a requester spent waiting on the other port.
module arb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the data port wins ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MBUS  = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [MBUS-1:0] ZERO_WORD = '0;

  arb_state_t       state;
  arb_state_t       next_state;
  grant_t           gnt;
  grant_t           tie_winner;
  logic             if_pend;
  logic             d_pend;
  logic             if_ack_c;
  logic             d_ack_c;
  logic             wait_inc;
  logic [CNT_W-1:0] cnt;

  assign if_pend = bus.if_req;
  assign d_pend  = bus.d_re | bus.d_we;

`ifdef MEM_ARB_RR_EN
  grant_t last_gnt;

  // Remembers who was granted most recently so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= GNT_IF;
    end else if ((state == IDLE) && (next_state != IDLE)) begin
      last_gnt <= gnt;
    end
  end

  assign tie_winner = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
`else
  assign tie_winner = GNT_D;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    gnt        = GNT_D;
    case (state)
      IDLE: begin
        if (if_pend && d_pend) begin
          gnt        = tie_winner;
          next_state = (tie_winner == GNT_D) ? D_ACC : IF_ACC;
        end else if (d_pend) begin
          gnt        = GNT_D;
          next_state = D_ACC;
        end else if (if_pend) begin
          gnt        = GNT_IF;
          next_state = IF_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        if (bus.mem_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Acks are gated by reset so nothing completes while the block is held in reset.
  always_comb begin
    if_ack_c = rst && (state == IF_ACC) && bus.mem_ready;
    d_ack_c  = rst && (state == D_ACC) && bus.mem_ready;
    wait_inc = ((state == IF_ACC) && d_pend) ||
               ((state == D_ACC) && if_pend) ||
               ((state == IDLE) && if_pend && d_pend);
  end

  assign bus.if_ack   = if_ack_c;
  assign bus.d_ack    = d_ack_c;
  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
  assign bus.stall    = rst && ((if_pend && !if_ack_c) || (d_pend && !d_ack_c));

  // Memory request is captured at grant and held stable; strobes drop on completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mem_addr  <= ZERO_WORD;
      bus.mem_wdata <= ZERO_WORD;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
    end else if ((state == IDLE) && (next_state != IDLE)) begin
      if (gnt == GNT_D) begin
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_we    <= bus.d_we;
        bus.mem_re    <= bus.d_re & ~bus.d_we;
      end else begin
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= ZERO_WORD;
        bus.mem_re    <= 1'b1;
        bus.mem_we    <= 1'b0;
      end
    end else if ((state != IDLE) && (next_state == IDLE)) begin
      bus.mem_re <= 1'b0;
      bus.mem_we <= 1'b0;
    end
  end

  arb_sat_counter #(
    .CNT_W(CNT_W)
  ) u_conflict_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wait_inc),
    .count(cnt)
  );

  assign bus.conflict_cnt = cnt;

endmodule
